// File: rtl/entrada_teclado_pkg.sv
// Shared constants for the keypad entry stage: key codes, FSM encoding and digit limit.
package entrada_teclado_pkg;

    localparam logic [3:0] COD_ENTER_DEF   = 4'hA;
    localparam logic [3:0] COD_BORRAR_DEF  = 4'hB;
    localparam int         MAX_DIGITOS_DEF = 9;

    localparam logic [1:0] VACIO = 2'd0;
    localparam logic [1:0] ACUM  = 2'd1;
    localparam logic [1:0] LLENO = 2'd2;

endpackage

// File: rtl/entrada_teclado_mult10_suma.sv
// Decimal shift-in step: suma_o = acc_i*10 + d_i, built from two shifts to avoid a multiplier.
module mult10_suma (
    input  logic [31:0] acc_i,
    input  logic [3:0]  d_i,
    output logic [31:0] suma_o
);

    assign suma_o = (acc_i << 3) + (acc_i << 1) + {28'd0, d_i};

endmodule

// File: rtl/entrada_teclado.sv
// Keypad entry stage: forwards PIN digits one by one, or accumulates a decimal amount
// that is committed on ENTER. All outputs are registered, latency one cycle.
module entrada_teclado
    import entrada_teclado_pkg::*;
#(
    parameter int         MAX_DIGITOS = MAX_DIGITOS_DEF,
    parameter logic [3:0] COD_ENTER   = COD_ENTER_DEF,
    parameter logic [3:0] COD_BORRAR  = COD_BORRAR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tecla_valida,
    input  logic [3:0]  tecla,
    input  logic        modo_monto,
    output logic [3:0]  digito,
    output logic        digito_stb,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        desborde,
    output logic [3:0]  num_digitos
);

    localparam logic [3:0] MAX4 = 4'(MAX_DIGITOS);

    logic [1:0]  estado_q, estado_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        modo_q;
    logic [3:0]  digito_q, digito_d;
    logic        digito_stb_q, digito_stb_d;
    logic [31:0] monto_q, monto_d;
    logic        monto_stb_q, monto_stb_d;
    logic        desborde_q, desborde_d;

    // A mode change (or PIN mode) clears the entry before the current key is applied.
    logic        limpiar;
    logic [1:0]  estado_ef;
    logic [31:0] acc_ef;
    logic [3:0]  cnt_ef;
    logic [31:0] acc_sig;
    logic        es_digito;

    assign limpiar   = (modo_monto != modo_q) || !modo_monto;
    assign estado_ef = limpiar ? VACIO : estado_q;
    assign acc_ef    = limpiar ? 32'd0 : acc_q;
    assign cnt_ef    = limpiar ? 4'd0  : cnt_q;
    assign es_digito = (tecla <= 4'd9);

    mult10_suma u_mult10_suma (
        .acc_i  (acc_ef),
        .d_i    (tecla),
        .suma_o (acc_sig)
    );

    always_comb begin
        estado_d     = estado_ef;
        acc_d        = acc_ef;
        cnt_d        = cnt_ef;
        digito_d     = digito_q;
        digito_stb_d = 1'b0;
        monto_d      = monto_q;
        monto_stb_d  = 1'b0;
        desborde_d   = 1'b0;

        if (tecla_valida) begin
            if (!modo_monto) begin
                if (es_digito) begin
                    digito_d     = tecla;
                    digito_stb_d = 1'b1;
                end
            end else if (es_digito) begin
                if (estado_ef == LLENO) begin
                    desborde_d = 1'b1;
                end else begin
                    // From VACIO acc_ef is zero, so the same step yields acc = d.
                    acc_d    = acc_sig;
                    cnt_d    = cnt_ef + 4'd1;
                    estado_d = ((cnt_ef + 4'd1) == MAX4) ? LLENO : ACUM;
                end
            end else if (tecla == COD_ENTER) begin
                if (estado_ef != VACIO) begin
                    monto_d     = acc_ef;
                    monto_stb_d = 1'b1;
                    acc_d       = 32'd0;
                    cnt_d       = 4'd0;
                    estado_d    = VACIO;
                end
            end else if (tecla == COD_BORRAR) begin
                acc_d    = 32'd0;
                cnt_d    = 4'd0;
                estado_d = VACIO;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q     <= VACIO;
            acc_q        <= 32'd0;
            cnt_q        <= 4'd0;
            modo_q       <= 1'b0;
            digito_q     <= 4'd0;
            digito_stb_q <= 1'b0;
            monto_q      <= 32'd0;
            monto_stb_q  <= 1'b0;
            desborde_q   <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            modo_q       <= modo_monto;
            digito_q     <= digito_d;
            digito_stb_q <= digito_stb_d;
            monto_q      <= monto_d;
            monto_stb_q  <= monto_stb_d;
            desborde_q   <= desborde_d;
        end
    end

    assign digito      = digito_q;
    assign digito_stb  = digito_stb_q;
    assign monto       = monto_q;
    assign monto_stb   = monto_stb_q;
    assign desborde    = desborde_q;
    assign num_digitos = cnt_q;

endmodule

// File: tb/tb_entrada_teclado.sv
// Directed self-checking bench for entrada_teclado: PIN forwarding, amount entry, overflow, clear, reset.
module tb_entrada_teclado;

    logic        clk;
    logic        rst;
    logic        tecla_valida;
    logic [3:0]  tecla;
    logic        modo_monto;
    logic [3:0]  digito;
    logic        digito_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic        desborde;
    logic [3:0]  num_digitos;

    int checks   = 0;
    int failures = 0;

    entrada_teclado dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_valida (tecla_valida),
        .tecla        (tecla),
        .modo_monto   (modo_monto),
        .digito       (digito),
        .digito_stb   (digito_stb),
        .monto        (monto),
        .monto_stb    (monto_stb),
        .desborde     (desborde),
        .num_digitos  (num_digitos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the key's response visible.
    task automatic press(input logic [3:0] k);
        tecla        = k;
        tecla_valida = 1'b1;
        @(negedge clk);
        tecla_valida = 1'b0;
        $display("key=%h modo=%0d -> digito=%0d dstb=%0b monto=%0d mstb=%0b desb=%0b num=%0d",
                 k, modo_monto, digito, digito_stb, monto, monto_stb, desborde, num_digitos);
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        tecla_valida = 1'b0;
        tecla        = 4'd0;
        modo_monto   = 1'b0;
        idle();
        idle();
        chk("reset_digito", 32'(digito), 32'd0);
        chk("reset_dstb", 32'(digito_stb), 32'd0);
        chk("reset_monto", monto, 32'd0);
        chk("reset_mstb", 32'(monto_stb), 32'd0);
        chk("reset_desb", 32'(desborde), 32'd0);
        chk("reset_num", 32'(num_digitos), 32'd0);
        rst = 1'b0;
        idle();

        // 1: PIN mode, keys 4,7,5,6 on alternate cycles
        press(4'd4);
        chk("pin4_dstb", 32'(digito_stb), 32'd1);
        chk("pin4_digito", 32'(digito), 32'd4);
        idle();
        chk("pin4_dstb_drop", 32'(digito_stb), 32'd0);
        press(4'd7);
        chk("pin7_digito", 32'(digito), 32'd7);
        chk("pin7_dstb", 32'(digito_stb), 32'd1);
        idle();
        press(4'd5);
        chk("pin5_digito", 32'(digito), 32'd5);
        idle();
        press(4'd6);
        chk("pin6_digito", 32'(digito), 32'd6);
        chk("pin6_mstb", 32'(monto_stb), 32'd0);
        chk("pin6_num", 32'(num_digitos), 32'd0);
        idle();
        press(4'hA);
        chk("pin_enter_dstb", 32'(digito_stb), 32'd0);
        chk("pin_enter_mstb", 32'(monto_stb), 32'd0);
        idle();

        // 2: amount 1,0,0,0,0 ENTER
        modo_monto = 1'b1;
        idle();
        press(4'd1);
        chk("amt_num1", 32'(num_digitos), 32'd1);
        chk("amt_dstb", 32'(digito_stb), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            press(4'd0);
            chk("amt_num_zero", 32'(num_digitos), 32'(i));
        end
        press(4'hA);
        chk("amt_mstb", 32'(monto_stb), 32'd1);
        chk("amt_monto", monto, 32'd10000);
        chk("amt_num_clr", 32'(num_digitos), 32'd0);
        idle();
        chk("amt_mstb_drop", 32'(monto_stb), 32'd0);
        chk("amt_monto_hold", monto, 32'd10000);

        // 3: ten nines, overflow on the tenth
        for (int i = 1; i <= 9; i++) begin
            press(4'd9);
            chk("nine_desb", 32'(desborde), 32'd0);
        end
        chk("nine_num9", 32'(num_digitos), 32'd9);
        press(4'd9);
        chk("nine_desb10", 32'(desborde), 32'd1);
        chk("nine_num_hold", 32'(num_digitos), 32'd9);
        idle();
        chk("nine_desb_drop", 32'(desborde), 32'd0);
        press(4'hA);
        chk("nine_mstb", 32'(monto_stb), 32'd1);
        chk("nine_monto", monto, 32'd999999999);
        idle();

        // 4: 3,2,BORRAR,7,ENTER then ENTER from empty
        press(4'd3);
        press(4'd2);
        chk("clr_num2", 32'(num_digitos), 32'd2);
        press(4'hB);
        chk("clr_num0", 32'(num_digitos), 32'd0);
        chk("clr_mstb", 32'(monto_stb), 32'd0);
        press(4'd7);
        press(4'hA);
        chk("clr_mstb7", 32'(monto_stb), 32'd1);
        chk("clr_monto7", monto, 32'd7);
        idle();
        chk("clr_mstb_drop", 32'(monto_stb), 32'd0);
        press(4'hA);
        chk("empty_enter_mstb", 32'(monto_stb), 32'd0);
        chk("empty_enter_monto", monto, 32'd7);
        idle();

        // 5: back-to-back 2,5,ENTER then PIN key 9 with the mode switch in the same cycle
        press(4'd2);
        chk("b2b_num1", 32'(num_digitos), 32'd1);
        press(4'd5);
        chk("b2b_num2", 32'(num_digitos), 32'd2);
        press(4'hA);
        chk("b2b_mstb", 32'(monto_stb), 32'd1);
        chk("b2b_monto", monto, 32'd25);
        modo_monto = 1'b0;
        press(4'd9);
        chk("b2b_dstb", 32'(digito_stb), 32'd1);
        chk("b2b_digito", 32'(digito), 32'd9);
        chk("b2b_mstb_drop", 32'(monto_stb), 32'd0);
        idle();

        // 6: async reset mid-entry
        modo_monto = 1'b1;
        idle();
        press(4'd8);
        press(4'd8);
        chk("rst_pre_num", 32'(num_digitos), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_num", 32'(num_digitos), 32'd0);
        chk("arst_monto", monto, 32'd0);
        chk("arst_digito", 32'(digito), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        press(4'hA);
        chk("arst_enter_mstb", 32'(monto_stb), 32'd0);
        chk("arst_enter_monto", monto, 32'd0);
        idle();

        // mode toggle mid-entry clears the count
        press(4'd3);
        press(4'd4);
        chk("tog_num2", 32'(num_digitos), 32'd2);
        modo_monto = 1'b0;
        idle();
        chk("tog_num0", 32'(num_digitos), 32'd0);
        modo_monto = 1'b1;
        idle();
        press(4'hA);
        chk("tog_enter_mstb", 32'(monto_stb), 32'd0);
        press(4'd6);
        chk("tog_num1", 32'(num_digitos), 32'd1);
        press(4'hA);
        chk("tog_monto", monto, 32'd6);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
